// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide RAM port shared between MEM-stage byte accesses
// (always first) and a 4-byte little-endian instruction-fetch engine for IF.
// Optional macro MEMCTRL_IF_FLUSH_EN adds if_flush_i to abort a fetch.
module mem_ctrl #(
    parameter int unsigned RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req_i,
    input  logic              mem_r_w_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [7:0]        mem_wdata_i,
    output logic [7:0]        mem_rdata_o,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic [31:0]       if_inst_o,
    output logic              if_done_o,
    input  logic [7:0]        ram_din_i,
    output logic [7:0]        ram_dout_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic              ram_wr_o
`ifdef MEMCTRL_IF_FLUSH_EN
    ,
    input  logic              if_flush_i
`endif
);

    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 8;
    localparam int unsigned IW     = 32;
    localparam int unsigned IDXW   = 3;
    localparam int unsigned PIDXW  = 2;
    localparam int unsigned BUFW   = 24;
    localparam int unsigned NBYTES = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     fetch_addr_q, fetch_addr_d;
    logic [IDXW-1:0]   issue_idx_q, issue_idx_d;
    logic              pend_q, pend_d;
    logic [PIDXW-1:0]  pend_idx_q, pend_idx_d;
    logic [BUFW-1:0]   buf_q, buf_d;
    logic [IW-1:0]     if_inst_q, if_inst_d;
    logic              if_done_q, if_done_d;

    logic              flush_c;
    logic              accept_c;
    logic              slot_free_c;
    logic              grant_c;
    logic              last_cap_c;
    logic [AW-1:0]     addr_sel_c;
    logic              unused_addr_c;

`ifdef MEMCTRL_IF_FLUSH_EN
    assign flush_c = if_flush_i;
`else
    assign flush_c = 1'b0;
`endif

    // Control terms shared by the FSM and datapath
    assign slot_free_c = (state_q == FETCH) && (issue_idx_q < IDXW'(NBYTES));
    assign grant_c     = slot_free_c && !mem_req_i;
    assign last_cap_c  = pend_q && (pend_idx_q == PIDXW'(NBYTES - 1));
    assign accept_c    = (state_q == IDLE) && if_req_i && !if_done_q;

    assign mem_rdata_o = ram_din_i;
    assign if_inst_o   = if_inst_q;
    assign if_done_o   = if_done_q;

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            issue_idx_q  <= '0;
            pend_q       <= 1'b0;
            pend_idx_q   <= '0;
            buf_q        <= '0;
            if_inst_q    <= '0;
            if_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            issue_idx_q  <= issue_idx_d;
            pend_q       <= pend_d;
            pend_idx_q   <= pend_idx_d;
            buf_q        <= buf_d;
            if_inst_q    <= if_inst_d;
            if_done_q    <= if_done_d;
        end
    end

    // Next-state logic; a flush overrides both acceptance and completion
    always_comb begin
        state_d = state_q;
        if (flush_c) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept_c)   state_d = FETCH;
                FETCH:   if (last_cap_c) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Fetch datapath: issue bytes on granted slots, capture the byte issued last cycle
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        issue_idx_d  = issue_idx_q;
        pend_d       = 1'b0;
        pend_idx_d   = pend_idx_q;
        buf_d        = buf_q;
        if_inst_d    = if_inst_q;
        if_done_d    = 1'b0;

        if (flush_c) begin
            issue_idx_d = '0;
            pend_idx_d  = '0;
        end else if (accept_c) begin
            fetch_addr_d = if_addr_i;
            issue_idx_d  = '0;
            pend_idx_d   = '0;
        end else if (state_q == FETCH) begin
            if (grant_c) begin
                pend_d      = 1'b1;
                pend_idx_d  = issue_idx_q[PIDXW-1:0];
                issue_idx_d = issue_idx_q + IDXW'(1);
            end
            // The pending byte belongs to IF even if MEM owns the port now
            if (pend_q) begin
                case (pend_idx_q)
                    2'd0: buf_d[7:0]   = ram_din_i;
                    2'd1: buf_d[15:8]  = ram_din_i;
                    2'd2: buf_d[23:16] = ram_din_i;
                    default: begin
                        if_inst_d = {ram_din_i, buf_q};
                        if_done_d = 1'b1;
                    end
                endcase
            end
        end
    end

    // RAM port mux, MEM first
    always_comb begin
        addr_sel_c = '0;
        ram_wr_o   = 1'b0;
        ram_dout_o = '0;
        if (mem_req_i) begin
            addr_sel_c = mem_addr_i;
            ram_wr_o   = mem_r_w_i;
            ram_dout_o = mem_wdata_i;
        end else if (slot_free_c) begin
            addr_sel_c = fetch_addr_q + AW'(issue_idx_q);
            ram_dout_o = DW'(0);
        end
    end

    assign ram_addr_o    = addr_sel_c[RAM_AW-1:0];
    assign unused_addr_c = ^addr_sel_c[AW-1:RAM_AW];

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scenarios plus randomized MEM/IF traffic, checked
// against a slot-counting reference model and a shadow copy of RAM.
module tb_mem_ctrl;

    localparam int unsigned RAM_AW = 17;
    localparam int unsigned RAM_SZ = 1 << RAM_AW;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_req, mem_r_w;
    logic [31:0]       mem_addr;
    logic [7:0]        mem_wdata, mem_rdata;
    logic              if_req;
    logic [31:0]       if_addr, if_inst;
    logic              if_done;
    logic [7:0]        ram_din, ram_dout;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_wr;
    logic              if_flush;

    always #5 clk = ~clk;

    mem_ctrl #(.RAM_AW(RAM_AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req_i   (mem_req),
        .mem_r_w_i   (mem_r_w),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_rdata_o (mem_rdata),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_inst_o   (if_inst),
        .if_done_o   (if_done),
        .ram_din_i   (ram_din),
        .ram_dout_o  (ram_dout),
        .ram_addr_o  (ram_addr),
        .ram_wr_o    (ram_wr)
`ifdef MEMCTRL_IF_FLUSH_EN
        ,
        .if_flush_i  (if_flush)
`endif
    );

    // Synchronous RAM: one-cycle read latency
    logic [7:0] ram  [RAM_SZ];
    logic [7:0] refm [RAM_SZ];

    always @(posedge clk) begin
        if (ram_wr) ram[ram_addr] <= ram_dout;
        ram_din <= ram[ram_addr];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Stimulus for the next cycle
    logic        d_rst, d_mreq, d_rw, d_ifreq, d_flush;
    logic [31:0] d_maddr, d_ifaddr;
    logic [7:0]  d_wdata;

    // Reference model state
    bit          m_active;
    logic [31:0] m_addr;
    int          m_granted;
    bit          m_done_due;
    logic [31:0] m_inst;
    int          m_acc_cyc;
    bit          chk_on;
    bit          prev_rd;
    logic [RAM_AW-1:0] prev_rd_addr;
    int          cyc_n;
    int          done_cyc;

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [RAM_AW-1:0] lo;
        lo = a[RAM_AW-1:0];
        return refm[lo];
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_byte(a + 32'd3), ref_byte(a + 32'd2), ref_byte(a + 32'd1), ref_byte(a)};
    endfunction

    task automatic set_word(input logic [RAM_AW-1:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [RAM_AW-1:0] ai;
            ai = a + RAM_AW'(i);
            ram[ai]  <= w[8*i +: 8];
            refm[ai]  = w[8*i +: 8];
        end
    endtask

    // One clock cycle: check registered outputs, apply inputs, check the mux, advance the model
    task automatic cyc();
        logic [RAM_AW-1:0] ea;
        logic              ew;
        logic [7:0]        ed;
        logic [31:0]       fa;
        bit                next_due;
        @(negedge clk);
        cyc_n++;
        if (chk_on) begin
            chk("done", if_done, m_done_due);
            chk("inst", if_inst, m_inst);
            if (prev_rd) chk("rdata", mem_rdata, refm[prev_rd_addr]);
        end
        if (if_done === 1'b1) done_cyc = cyc_n;

        rst = d_rst; mem_req = d_mreq; mem_r_w = d_rw; mem_addr = d_maddr;
        mem_wdata = d_wdata; if_req = d_ifreq; if_addr = d_ifaddr; if_flush = d_flush;
        #1;

        ea = '0; ew = 1'b0; ed = '0;
        if (d_mreq) begin
            ea = d_maddr[RAM_AW-1:0]; ew = d_rw; ed = d_wdata;
        end else if (m_active && m_granted < 4) begin
            fa = m_addr + 32'(m_granted);
            ea = fa[RAM_AW-1:0];
        end
        if (chk_on) begin
            chk("ram_addr", ram_addr, ea);
            chk("ram_wr", ram_wr, ew);
            chk("ram_dout", ram_dout, ed);
        end

        prev_rd      = d_mreq && !d_rw;
        prev_rd_addr = d_maddr[RAM_AW-1:0];
        if (d_mreq && d_rw) refm[d_maddr[RAM_AW-1:0]] = d_wdata;

        next_due = 1'b0;
        if (d_rst) begin
            m_active = 1'b0; m_inst = '0; m_granted = 0;
        end else if (d_flush) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (d_ifreq && !m_done_due) begin
                m_active = 1'b1; m_addr = d_ifaddr; m_granted = 0; m_acc_cyc = cyc_n;
            end
        end else if (m_granted == 4) begin
            m_active = 1'b0; next_due = 1'b1; m_inst = ref_word(m_addr);
        end else if (!d_mreq) begin
            m_granted++;
        end
        m_done_due = next_due;
        if (d_rst) chk_on = 1'b1;
    endtask

    task automatic idle(input int n);
        d_mreq = 1'b0; d_ifreq = 1'b0; d_flush = 1'b0; d_rst = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic fetch_start(input logic [31:0] a);
        d_ifreq = 1'b1; d_ifaddr = a;
        cyc();
        d_ifreq = 1'b0;
    endtask

    task automatic mem_op(input logic rw, input logic [31:0] a, input logic [7:0] wd);
        d_mreq = 1'b1; d_rw = rw; d_maddr = a; d_wdata = wd;
        cyc();
        d_mreq = 1'b0;
    endtask

    initial begin
        logic [31:0] r, r2;
        logic [RAM_AW-1:0] lo;
        for (int i = 0; i < RAM_SZ; i++) begin
            r = $urandom;
            ram[i] <= r[7:0];
            refm[i] = r[7:0];
        end
        set_word(17'h00100, 32'h00500013);
        set_word(17'h00200, 32'h00100893);

        d_rst = 1'b1; d_mreq = 1'b0; d_rw = 1'b0; d_maddr = '0; d_wdata = '0;
        d_ifreq = 1'b0; d_ifaddr = '0; d_flush = 1'b0;
        cyc_n = 0; done_cyc = -1; chk_on = 1'b0; prev_rd = 1'b0;
        m_active = 1'b0; m_granted = 0; m_done_due = 1'b0; m_inst = '0; m_addr = '0; m_acc_cyc = 0;
        cyc(); cyc();
        idle(1);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_addr", 32'(ram_addr), 32'h0);

        // Uncontended fetch
        done_cyc = -1;
        fetch_start(32'h0000_0100);
        idle(7);
        chk("t1_inst", if_inst, 32'h00500013);
        chk("t1_lat", 32'(done_cyc - m_acc_cyc - 1), 32'd5);

        // MEM write then read back
        mem_op(1'b1, 32'h0000_0020, 8'hAB);
        mem_op(1'b0, 32'h0000_0020, 8'h00);
        idle(1);
        chk("t2_rdata", mem_rdata, 8'hAB);

        // Two stolen slots mid-fetch, the first right after an IF issue
        done_cyc = -1;
        fetch_start(32'h0000_0100);
        idle(1);
        mem_op(1'b0, 32'h0000_0020, 8'h00);
        mem_op(1'b0, 32'h0001_0101, 8'h00);
        idle(8);
        chk("t3_inst", if_inst, 32'h00500013);
        chk("t3_lat", 32'(done_cyc - m_acc_cyc - 1), 32'd7);

        // Reset after two bytes captured
        fetch_start(32'h0000_0100);
        idle(3);
        d_rst = 1'b1; cyc(); d_rst = 1'b0;
        done_cyc = -1;
        idle(8);
        chk("t5_nodone", 32'(done_cyc), 32'hFFFF_FFFF);
        fetch_start(32'h0000_0100);
        idle(7);
        chk("t5_inst", if_inst, 32'h00500013);

        // Fetch across the 32-bit address wrap
        fetch_start(32'hFFFF_FFFE);
        idle(7);
        chk("wrap_inst", if_inst, {refm[1], refm[0], refm[RAM_SZ-1], refm[RAM_SZ-2]});

`ifdef MEMCTRL_IF_FLUSH_EN
        // Flush on the byte-3 capture edge, then refetch elsewhere
        done_cyc = -1;
        fetch_start(32'h0000_0100);
        idle(4);
        d_flush = 1'b1; d_ifreq = 1'b1; d_ifaddr = 32'h0000_0200; cyc();
        d_flush = 1'b0;
        chk("t6_nodone_pre", 32'(done_cyc), 32'hFFFF_FFFF);
        fetch_start(32'h0000_0200);
        idle(1);
        chk("t6_nodone", 32'(done_cyc), 32'hFFFF_FFFF);
        idle(6);
        chk("t6_inst", if_inst, 32'h00100893);
`endif

        // Randomized traffic
        for (int it = 0; it < 600; it++) begin
            r = $urandom;
            r2 = $urandom;
            d_rst = (r[6:0] == 7'd0);
            d_mreq = !d_rst && (r[15:8] < 8'd90);
            d_rw = r[16];
            if (d_rw) lo = {2'b01, r2[14:0]};
            else      lo = r2[16:0];
            d_maddr = {r2[31:17], lo};
            d_wdata = r[31:24];
            if (!m_active) d_ifreq = r[17] | r[18];
            else           d_ifreq = r[17];
            r = $urandom;
            d_ifaddr = {r[31:17], 2'b00, r[14:0]};
`ifdef MEMCTRL_IF_FLUSH_EN
            d_flush = (r[16:15] == 2'b11) && (r2[16:15] == 2'b11);
`else
            d_flush = 1'b0;
`endif
            cyc();
        end
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
